image_load_sched: RTL and testbench
===================================

IMAGE_LOAD_SCHED -- requirements
Module: image_load_sched

Interface
REQ-001 Parameter NPIX, default 64: pixels per frame; the address width is 6 bits (log2 NPIX).
REQ-002 Parameter START_BYTE, default 8'h01: frame header byte.
REQ-003 Parameter TIMEOUT_CYC, default 1_000_000: maximum idle clocks between bytes while loading.
REQ-004 Parameter ASCII_BASE, default 8'h30: offset added to the class index for the reply byte.
REQ-005 clk  in  1  system clock; all state updates on rising edge.
REQ-006 reset  in  1  one clock; reset is asynchronous and active-low (reset=0 resets).
REQ-007 rx_data  in  8  byte from the UART receiver; valid only when rx_ready=1.
REQ-008 rx_ready  in  1  one-cycle strobe per received byte.
REQ-009 wr_en  out  1  write enable to the input-pixel BRAM.
REQ-010 wr_addr  out  6  pixel address, row-major (row = [5:3], col = [2:0]).
REQ-011 wr_data  out  8  pixel byte.
REQ-012 pipe_start  out  1  one-cycle pulse that launches the conv/dense pipeline.
REQ-013 pipe_busy  in  1  pipeline busy level.
REQ-014 pipe_done  in  1  one-cycle strobe: classification finished.
REQ-015 result_index  in  2  class index; valid in the pipe_done cycle.
REQ-016 tx_start  out  1  one-cycle request to the UART transmitter.
REQ-017 tx_data  out  8  reply byte; held stable from tx_start until tx_busy falls.
REQ-018 tx_busy  in  1  transmitter busy level.
REQ-019 state_id  out  3  encoded current state, for debug.
REQ-020 err_timeout  out  1  one-cycle pulse when a frame is aborted by timeout.

Function
REQ-021 State machine states, with their state_id encodings: IDLE=0, LOAD=1, KICK=2, COMPUTE=3, SEND=4, WAIT_TX=5.
REQ-022 IDLE transitions to LOAD on rx_ready with rx_data==START_BYTE; all other bytes are ignored. The header byte is not written.
REQ-023 LOAD behaviour on each rx_ready: wr_en=1, wr_data=rx_data and wr_addr=byte count, all combinational in the same cycle; the count increments on that edge.
REQ-024 LOAD ends when the NPIX-th byte is written (address NPIX-1); the next state is KICK. The count then wraps to 0 and does not carry over.
REQ-025 A START_BYTE value received inside LOAD is treated as pixel data, not as a restart.
REQ-026 Timeout: the idle counter clears on every rx_ready in LOAD.
REQ-027 On timeout, when the idle counter reaches TIMEOUT_CYC-1 without rx_ready, the block pulses err_timeout for 1 cycle, returns to IDLE and clears the count; no pipe_start is issued.
REQ-028 If rx_ready and the timeout terminal count coincide, the byte wins: it is written and the idle counter clears.
REQ-029 KICK waits while pipe_busy=1. When pipe_busy=0, the block asserts pipe_start for exactly 1 cycle and moves to COMPUTE.
REQ-030 COMPUTE: on pipe_done, the block latches tx_data = ASCII_BASE + {6'b0, result_index} and moves to SEND.
REQ-031 rx_ready is ignored in KICK, COMPUTE, SEND and WAIT_TX; bytes arriving then are dropped and never written.
REQ-032 SEND asserts tx_start for 1 cycle when tx_busy=0, then moves to WAIT_TX; while tx_busy=1 it holds without asserting.
REQ-033 WAIT_TX returns to IDLE on the first cycle tx_busy=0 at least one cycle after tx_start.
REQ-034 pipe_done outside COMPUTE is ignored.
REQ-035 wr_en, pipe_start, tx_start and err_timeout are never asserted together.
REQ-036 Minimum latency from the final pixel's rx_ready to pipe_start is 2 clocks (LOAD→KICK, KICK pulse) when pipe_busy=0.

Reset
REQ-037 On reset=0, asynchronously: state=IDLE, count=0, idle counter=0.
REQ-038 On reset=0, asynchronously: wr_en=0, wr_addr=0, wr_data=0, pipe_start=0, tx_start=0, tx_data=0, err_timeout=0, state_id=0.
REQ-039 Reset asserted mid-LOAD or mid-COMPUTE abandons the frame; after release, no pipe_start or tx_start is issued until a new START_BYTE plus NPIX bytes arrive.
REQ-040 Reset release is synchronised externally; no output toggles in the first cycle after release unless an input event occurs.

Verification
REQ-041 Send 0x01 then bytes 0x00..0x3F, with pipe_busy=0 -> 64 wr_en pulses at addr 0..63 with data = addr, and pipe_start exactly 2 clocks after the last byte.
REQ-042 Complete a load, then pulse pipe_done with result_index=2 while tx_busy=0 -> tx_start with tx_data=0x32, then IDLE once tx_busy falls.
REQ-043 Send 0x01 plus 10 bytes, then silence with TIMEOUT_CYC=100 -> err_timeout pulse at idle cycle 99, no pipe_start; a fresh 0x01+64 frame then loads from addr 0.
REQ-044 Bytes 0x05 and 0x7F in IDLE, then 0x01 plus 64 bytes where byte 5 is 0x01 -> no writes for the leading bytes; 0x01 is written at addr 5; exactly 64 writes.
REQ-045 Hold pipe_busy=1 at the end of LOAD for 20 cycles -> pipe_start is issued in the first cycle pipe_busy=0; hold tx_busy=1 in SEND -> tx_start is deferred identically.
REQ-046 Assert reset at byte 30 of LOAD -> all outputs go to 0 immediately; extra bytes without a header produce no writes.

Source files
------------

// File: rtl/image_load_sched.sv
// image_load_sched: loads a START_BYTE-framed image from the UART into pixel BRAM,
// launches the classifier pipeline and replies with the ASCII class digit.
module image_load_sched #(
   parameter int         NPIX        = 64,
   parameter logic [7:0] START_BYTE  = 8'h01,
   parameter int         TIMEOUT_CYC = 1_000_000,
   parameter logic [7:0] ASCII_BASE  = 8'h30,
   localparam int        AW          = $clog2(NPIX),
   localparam int        IW          = $clog2(TIMEOUT_CYC)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [7:0]    rx_data,
   input  logic          rx_ready,
   output logic          wr_en,
   output logic [AW-1:0] wr_addr,
   output logic [7:0]    wr_data,
   output logic          pipe_start,
   input  logic          pipe_busy,
   input  logic          pipe_done,
   input  logic [1:0]    result_index,
   output logic          tx_start,
   output logic [7:0]    tx_data,
   input  logic          tx_busy,
   output logic [2:0]    state_id,
   output logic          err_timeout
);
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LOAD    = 3'd1,
      KICK    = 3'd2,
      COMPUTE = 3'd3,
      SEND    = 3'd4,
      WAIT_TX = 3'd5
   } state_t;

   state_t        state, nxt;
   logic [AW-1:0] count;
   logic [IW-1:0] idle;
   logic          last_pix, idle_end, go_pipe, go_tx;

   assign last_pix    = count == AW'(NPIX - 1);
   assign idle_end    = idle == IW'(TIMEOUT_CYC - 1);
   assign wr_en       = state == LOAD && rx_ready;
   assign err_timeout = state == LOAD && !rx_ready && idle_end;
   assign go_pipe     = state == KICK && !pipe_busy;
   assign go_tx       = state == SEND && !tx_busy;
   assign wr_addr     = wr_en ? count : '0;
   assign wr_data     = wr_en ? rx_data : '0;
   assign state_id    = state;

   always_comb begin
      nxt = state;
      case (state)
         IDLE:    nxt = (rx_ready && rx_data == START_BYTE) ? LOAD : IDLE;
         LOAD:    nxt = (wr_en && last_pix) ? KICK : err_timeout ? IDLE : LOAD;
         KICK:    nxt = go_pipe ? COMPUTE : KICK;
         COMPUTE: nxt = pipe_done ? SEND : COMPUTE;
         SEND:    nxt = go_tx ? WAIT_TX : SEND;
         // tx_start is high in the first WAIT_TX cycle, so leaving is deferred by at least one cycle
         WAIT_TX: nxt = (!tx_busy && !tx_start) ? IDLE : WAIT_TX;
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state      <= IDLE;
         count      <= '0;
         idle       <= '0;
         pipe_start <= 1'b0;
         tx_start   <= 1'b0;
         tx_data    <= '0;
      end else begin
         state      <= nxt;
         pipe_start <= go_pipe;
         tx_start   <= go_tx;
         idle       <= (state == LOAD && !rx_ready && !idle_end) ? idle + 1'b1 : '0;
         if (wr_en)
            count <= last_pix ? '0 : count + 1'b1;
         else if (err_timeout)
            count <= '0;
         if (state == COMPUTE && pipe_done)
            tx_data <= ASCII_BASE + {6'b0, result_index};
      end
endmodule

// File: tb/tb_image_load_sched.sv
// tb_image_load_sched: vector table, directed corner sequences and randomized frames
// checked against a frame-level expectation model.
module tb_image_load_sched;
   typedef struct {
      logic       rdy;
      logic [7:0] d;
      logic [2:0] st;
      logic       we;
      logic [5:0] a;
      logic [7:0] wd;
   } vec_t;

   logic clk = 1'b0, reset = 1'b1, rx_ready = 1'b0, pipe_busy = 1'b0, pipe_done = 1'b0, tx_busy = 1'b0;
   logic [7:0] rx_data = '0;
   logic [1:0] result_index = '0;
   logic wr_en, pipe_start, tx_start, err_timeout;
   logic [5:0] wr_addr;
   logic [7:0] wr_data, tx_data;
   logic [2:0] state_id;
   int errors = 0, checks = 0, cyc = 0, n_ps = 0, n_err = 0, excl = 0;
   int last_wr_cyc = 0, ps_cyc = 0, tx_cyc = 0, err_cyc = 0, exp_ps = 0, exp_err = 0;
   logic [13:0] wq[$], exp_w[$];
   logic [7:0] txq[$], exp_tx[$];
   vec_t tbl[8];

   image_load_sched #(.TIMEOUT_CYC(100)) dut (
      .clk(clk), .reset(reset), .rx_data(rx_data), .rx_ready(rx_ready),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .pipe_start(pipe_start),
      .pipe_busy(pipe_busy), .pipe_done(pipe_done), .result_index(result_index),
      .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
      .state_id(state_id), .err_timeout(err_timeout)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // Monitor: records every output event with the cycle it occurred in
   always @(negedge clk) if (reset) begin
      if (wr_en) begin wq.push_back({wr_addr, wr_data}); last_wr_cyc = cyc; end
      if (pipe_start) begin n_ps++; ps_cyc = cyc; end
      if (tx_start) begin txq.push_back(tx_data); tx_cyc = cyc; end
      if (err_timeout) begin n_err++; err_cyc = cyc; end
      if (int'(wr_en) + int'(pipe_start) + int'(tx_start) + int'(err_timeout) > 1) excl++;
   end

   initial begin
      #800us;
      $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
      $fatal(1);
   end

   function automatic logic [28:0] outs();
      return {wr_en, wr_addr, wr_data, pipe_start, tx_start, tx_data, err_timeout, state_id};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic gap(input int n);
      repeat (n) tick();
   endtask

   task automatic send(input logic [7:0] b);
      rx_data = b;
      rx_ready = 1'b1;
      tick();
      rx_ready = 1'b0;
   endtask

   task automatic wait_idle(input string nm);
      int n = 0;
      while (state_id != 3'd0 && n < 200) begin tick(); n++; end
      chk(nm, state_id, 0);
   endtask

   task automatic cmp_writes(input string nm);
      int bad = int'(wq.size() != exp_w.size());
      for (int i = 0; i < wq.size() && i < exp_w.size(); i++) if (wq[i] !== exp_w[i]) bad++;
      chk(nm, bad, 0);
      wq.delete();
      exp_w.delete();
   endtask

   task automatic cmp_tx(input string nm);
      int bad = int'(txq.size() != exp_tx.size());
      for (int i = 0; i < txq.size() && i < exp_tx.size(); i++) if (txq[i] !== exp_tx[i]) bad++;
      chk(nm, bad, 0);
      txq.delete();
      exp_tx.delete();
   endtask

   // Must be called in COMPUTE: classifier result, transmitter handshake, return to IDLE
   task automatic finish_tx(input logic [1:0] idx, input int busy_cyc);
      int n = 0;
      tx_busy = busy_cyc != 0;
      result_index = idx;
      pipe_done = 1'b1;
      tick();
      pipe_done = 1'b0;
      gap(busy_cyc);
      tx_busy = 1'b0;
      while (!tx_start && n < 50) begin tick(); n++; end
      tx_busy = 1'b1;
      gap(2);
      tx_busy = 1'b0;
      wait_idle("idle_after_reply");
   endtask

   task automatic rand_frame(input bit to);
      logic [7:0] b;
      logic [1:0] idx;
      int n = to ? $urandom_range(1, 63) : 64;
      repeat ($urandom_range(0, 3)) begin
         b = 8'($urandom_range(2, 255));
         send(b);
         gap($urandom_range(0, 2));
      end
      pipe_busy = 1'($urandom_range(0, 1));
      send(8'h01);
      for (int i = 0; i < n; i++) begin
         b = 8'($urandom);
         exp_w.push_back({6'(i), b});
         send(b);
         if (i < n - 1) gap($urandom_range(0, 63) == 0 ? 99 : $urandom_range(0, 3));
      end
      if (to) begin
         gap(104);
         exp_err++;
         pipe_busy = 1'b0;
      end else begin
         gap($urandom_range(0, 6));
         pipe_busy = 1'b0;
         n = 0;
         while (state_id != 3'd3 && n < 20) begin tick(); n++; end
         exp_ps++;
         send(8'h01);
         send(8'($urandom));
         idx = 2'($urandom);
         exp_tx.push_back(8'h30 + {6'b0, idx});
         finish_tx(idx, $urandom_range(0, 4));
      end
      cmp_writes("rand_writes");
      chk("rand_pipe_starts", n_ps, exp_ps);
      chk("rand_timeouts", n_err, exp_err);
      cmp_tx("rand_replies");
   endtask

   initial begin
      logic [7:0] b;
      int n, d, ps0, err0;
      tbl = '{
         '{1'b0, 8'h00, 3'd0, 1'b0, 6'd0, 8'h00},
         '{1'b1, 8'h05, 3'd0, 1'b0, 6'd0, 8'h00},
         '{1'b1, 8'h7F, 3'd0, 1'b0, 6'd0, 8'h00},
         '{1'b1, 8'h01, 3'd0, 1'b0, 6'd0, 8'h00},
         '{1'b1, 8'hAA, 3'd1, 1'b1, 6'd0, 8'hAA},
         '{1'b0, 8'h00, 3'd1, 1'b0, 6'd0, 8'h00},
         '{1'b1, 8'h01, 3'd1, 1'b1, 6'd1, 8'h01},
         '{1'b1, 8'h3C, 3'd1, 1'b1, 6'd2, 8'h3C}
      };
      #3 reset = 1'b0;
      gap(3);
      chk("reset_outputs", outs(), 0);
      reset = 1'b1;
      tick();
      chk("quiet_after_release", outs(), 0);
      for (int i = 0; i < 8; i++) begin
         rx_ready = tbl[i].rdy;
         rx_data = tbl[i].d;
         @(negedge clk);
         chk($sformatf("vec%0d", i), {state_id, wr_en, wr_addr, wr_data},
             {tbl[i].st, tbl[i].we, tbl[i].a, tbl[i].wd});
         tick();
      end
      rx_ready = 1'b0;
      for (int i = 3; i < 30; i++) send(8'(i));
      rx_data = 8'hEE;
      rx_ready = 1'b1;
      #2 reset = 1'b0;
      #1 chk("async_reset_mid_load", outs(), 0);
      rx_ready = 1'b0;
      gap(2);
      reset = 1'b1;
      wq.delete();
      ps0 = n_ps;
      for (int i = 0; i < 5; i++) send(8'(8'h10 + i));
      gap(3);
      chk("no_writes_without_header", wq.size(), 0);
      chk("idle_after_abandon", state_id, 0);
      chk("no_pipe_start_after_reset", n_ps - ps0, 0);
      txq.delete();
      pipe_done = 1'b1;
      tick();
      pipe_done = 1'b0;
      gap(3);
      chk("pipe_done_ignored_in_idle", {state_id, 8'(txq.size())}, 0);
      send(8'h01);
      for (int i = 0; i < 64; i++) begin exp_w.push_back({6'(i), 8'(i)}); send(8'(i)); end
      gap(4);
      cmp_writes("ramp_frame_writes");
      chk("pipe_start_latency", ps_cyc - last_wr_cyc, 2);
      chk("compute_state", state_id, 3);
      send(8'h01);
      send(8'h55);
      tx_busy = 1'b0;
      result_index = 2'd2;
      pipe_done = 1'b1;
      tick();
      pipe_done = 1'b0;
      n = 0;
      while (!tx_start && n < 20) begin tick(); n++; end
      chk("tx_start_seen", tx_start, 1);
      chk("tx_data_class2", tx_data, 8'h32);
      tx_busy = 1'b1;
      gap(3);
      chk("wait_tx_state", state_id, 5);
      chk("tx_data_held", tx_data, 8'h32);
      tx_busy = 1'b0;
      wait_idle("idle_after_tx");
      chk("stray_bytes_dropped", wq.size(), 0);
      txq.delete();
      pipe_busy = 1'b1;
      send(8'h01);
      for (int i = 0; i < 64; i++) begin b = 8'($urandom); exp_w.push_back({6'(i), b}); send(b); end
      ps0 = n_ps;
      gap(20);
      chk("kick_holds_while_busy", n_ps - ps0, 0);
      chk("kick_state", state_id, 2);
      pipe_busy = 1'b0;
      d = cyc;
      gap(3);
      chk("kick_release_timing", ps_cyc - d, 1);
      cmp_writes("busy_frame_writes");
      tx_busy = 1'b1;
      result_index = 2'd1;
      pipe_done = 1'b1;
      tick();
      pipe_done = 1'b0;
      gap(20);
      chk("send_holds_while_busy", txq.size(), 0);
      chk("send_state", state_id, 4);
      tx_busy = 1'b0;
      d = cyc;
      gap(3);
      chk("send_release_timing", tx_cyc - d, 1);
      chk("tx_data_class1", tx_data, 8'h31);
      wait_idle("idle_after_deferred_tx");
      err0 = n_err;
      ps0 = n_ps;
      wq.delete();
      send(8'h01);
      for (int i = 0; i < 10; i++) send(8'(100 + i));
      gap(99);
      chk("no_early_timeout", n_err - err0, 0);
      gap(3);
      chk("timeout_pulse", n_err - err0, 1);
      chk("timeout_cycle", err_cyc - last_wr_cyc, 100);
      chk("idle_after_timeout", state_id, 0);
      chk("no_pipe_start_on_timeout", n_ps - ps0, 0);
      wq.delete();
      send(8'h05);
      send(8'h7F);
      send(8'h01);
      for (int i = 0; i < 64; i++) begin
         b = (i == 5) ? 8'h01 : 8'(i * 3 + 7);
         exp_w.push_back({6'(i), b});
         send(b);
         if (i == 0) gap(99);
      end
      gap(3);
      cmp_writes("frame_after_timeout");
      chk("byte_wins_terminal_count", n_err - err0, 1);
      chk("pipe_start_after_reload", n_ps - ps0, 1);
      finish_tx(2'd0, 0);
      exp_ps = n_ps;
      exp_err = n_err;
      txq.delete();
      for (int f = 0; f < 24; f++) rand_frame($urandom_range(0, 4) == 0);
      chk("exclusive_outputs", excl, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
